// File: rtl/md_sixbutton_reader.sv
// Host-side poller for the DB9 six-button pad protocol: walks the select line through
// six phases once per poll, then reports pad type and the pressed-button vector.
module md_sixbutton_reader #(
    parameter int HALF_CYCLES = 40,
    parameter int POLL_CYCLES = 80000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p1,
    input  logic        p2,
    input  logic        p3,
    input  logic        p4,
    input  logic        p6,
    input  logic        p9,
    output logic        p7,
    output logic [11:0] buttons,
    output logic        valid,
    output logic        six_button,
    output logic        pad_present
);

    localparam int            CW        = $clog2(POLL_CYCLES + 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {WAIT, PH0, PH1, PH2, PH3, PH4, PH5} state_t;

    state_t        state, state_next;
    logic [CW-1:0] poll_cnt, poll_next;
    logic [CW-1:0] phase_cnt, phase_next;
    logic          phase_end;
    logic          p7_next;
    logic [5:0]    pins_meta, pins_sync;
    logic [7:0]    shadow_lo;
    logic [3:0]    shadow_hi;
    logic          id3, id6a, id6b, six_now;

    // Pin order {p9, p6, p4, p3, p2, p1}; idle value is the pulled-up "no pad" level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pins_meta <= '1;
            pins_sync <= '1;
        end else begin
            pins_meta <= {p9, p6, p4, p3, p2, p1};
            pins_sync <= pins_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT;
            poll_cnt  <= '0;
            phase_cnt <= '0;
            p7        <= 1'b1;
        end else begin
            state     <= state_next;
            poll_cnt  <= poll_next;
            phase_cnt <= phase_next;
            p7        <= p7_next;
        end
    end

    // The poll counter free-runs over POLL_CYCLES so PH0 starts are exactly periodic.
    always_comb begin
        state_next = state;
        poll_next  = (poll_cnt == POLL_LAST) ? '0 : poll_cnt + CW'(1);
        phase_end  = 1'b0;
        phase_next = '0;
        if (state != WAIT) begin
            phase_end  = (phase_cnt == HALF_LAST);
            phase_next = phase_end ? '0 : phase_cnt + CW'(1);
        end
        case (state)
            WAIT:    if (poll_cnt == POLL_LAST) state_next = PH0;
            PH0:     if (phase_end) state_next = PH1;
            PH1:     if (phase_end) state_next = PH2;
            PH2:     if (phase_end) state_next = PH3;
            PH3:     if (phase_end) state_next = PH4;
            PH4:     if (phase_end) state_next = PH5;
            PH5:     if (phase_end) state_next = WAIT;
            default: state_next = WAIT;
        endcase
        p7_next = (state_next == WAIT) || (state_next == PH0) ||
                  (state_next == PH2)  || (state_next == PH4);
    end

    assign id6b    = (pins_sync[3:0] == 4'hF);
    assign six_now = id3 && id6a && id6b;

    // Raw active-low samples collect in the shadow; outputs change only at the end of PH5.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_lo   <= '1;
            shadow_hi   <= '1;
            id3         <= 1'b0;
            id6a        <= 1'b0;
            buttons     <= '0;
            valid       <= 1'b0;
            six_button  <= 1'b0;
            pad_present <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (phase_end) begin
                case (state)
                    PH0: shadow_lo[5:0] <= pins_sync;
                    PH1: begin
                        shadow_lo[7:6] <= pins_sync[5:4];
                        id3            <= (pins_sync[3:2] == 2'b00);
                    end
                    PH3: id6a <= (pins_sync[3:0] == 4'h0);
                    PH4: shadow_hi <= pins_sync[3:0];
                    PH5: begin
                        valid         <= 1'b1;
                        pad_present   <= id3;
                        six_button    <= six_now;
                        buttons[7:0]  <= id3 ? ~shadow_lo : 8'h00;
                        buttons[11:8] <= six_now ? ~shadow_hi : 4'h0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_sixbutton_reader.sv
// Bench for md_sixbutton_reader: a behavioural three/six-button pad drives the pins and a
// rule-level model predicts each poll's decode, phase timing and reset behaviour.
module tb_md_sixbutton_reader;

    localparam int H           = 4;
    localparam int P           = 100;
    localparam int PAD_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        p7;
    logic [11:0] buttons;
    logic        valid;
    logic        six_button;
    logic        pad_present;

    int          n_assert = 0;
    int          n_fail   = 0;

    int          pad_type = 0;
    logic [11:0] pressed  = 12'h000;
    int          step     = 0;
    int          idle     = 0;
    logic        p7_last  = 1'b1;
    logic [5:0]  pad_pins;

    md_sixbutton_reader #(.HALF_CYCLES(H), .POLL_CYCLES(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .p1          (pad_pins[0]),
        .p2          (pad_pins[1]),
        .p3          (pad_pins[2]),
        .p4          (pad_pins[3]),
        .p6          (pad_pins[4]),
        .p9          (pad_pins[5]),
        .p7          (p7),
        .buttons     (buttons),
        .valid       (valid),
        .six_button  (six_button),
        .pad_present (pad_present)
    );

    always #5 clk = ~clk;

    // Pad step counter: advances on every select edge, falls back to 0 after a quiet spell.
    always @(p7 or posedge clk) begin
        if (p7 !== p7_last) begin
            p7_last = p7;
            step    = step + 1;
            idle    = 0;
        end else begin
            idle = idle + 1;
            if (idle > PAD_TIMEOUT) step = 0;
        end
    end

    // Pin order {p9, p6, p4, p3, p2, p1}; type 0 = unplugged, 1 = three-button, 2 = six-button.
    always_comb begin
        pad_pins = 6'h3F;
        if (pad_type != 0) begin
            if (p7) begin
                pad_pins = ~pressed[5:0];
                if (pad_type == 2 && step == 4) pad_pins[3:0] = ~pressed[11:8];
            end else begin
                pad_pins = {~pressed[7], ~pressed[6], 2'b00, ~pressed[1], ~pressed[0]};
                if (pad_type == 2 && step == 3) pad_pins[3:0] = 4'h0;
                if (pad_type == 2 && step == 5) pad_pins[3:0] = 4'hF;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int pt, input logic [11:0] pr);
        pad_type = pt;
        pressed  = pr;
    endtask

    task automatic check_decode(input string tag, input int pt, input logic [11:0] pr);
        logic [11:0] exp_buttons;
        exp_buttons = (pt == 2) ? pr : (pt == 1) ? {4'h0, pr[7:0]} : 12'h000;
        check_output({tag, "_buttons"}, 32'(buttons), 32'(exp_buttons));
        check_output({tag, "_six"}, 32'(six_button), 32'(pt == 2));
        check_output({tag, "_present"}, 32'(pad_present), 32'(pt != 0));
    endtask

    task automatic wait_valid(output int waited);
        waited = -1;
        for (int n = 1; n <= 2 * P; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                waited = n;
                break;
            end
        end
    endtask

    int          edge_at[$];
    int          valid_at[$];
    logic [11:0] cap_buttons;
    logic        cap_six, cap_present;
    logic        prev_p7;
    int          waited;
    int          pt_list[$];
    logic [11:0] pr_list[$];

    initial begin
        reset = 1'b0;
        apply_stimulus(2, 12'hC41);
        repeat (3) @(negedge clk);
        check_output("rst_p7", 32'(p7), 32'd1);
        check_output("rst_buttons", 32'(buttons), 32'd0);
        check_output("rst_valid", 32'(valid), 32'd0);
        check_output("rst_six", 32'(six_button), 32'd0);
        check_output("rst_present", 32'(pad_present), 32'd0);

        reset       = 1'b1;
        prev_p7     = 1'b1;
        cap_buttons = '0;
        cap_six     = 1'b0;
        cap_present = 1'b0;
        for (int n = 1; n <= 2 * P + 10; n++) begin
            @(posedge clk);
            #1;
            if (p7 !== prev_p7) edge_at.push_back(n);
            prev_p7 = p7;
            if (valid) begin
                valid_at.push_back(n);
                if (valid_at.size() == 1) begin
                    cap_buttons = buttons;
                    cap_six     = six_button;
                    cap_present = pad_present;
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            int exp_edge;
            exp_edge = (k < 6) ? P + H * (k + 1) : 2 * P + H;
            check_output($sformatf("edge%0d", k),
                         32'((k < edge_at.size()) ? edge_at[k] : -1), 32'(exp_edge));
        end
        check_output("valid_count", 32'(valid_at.size()), 32'd1);
        check_output("valid_cycle", 32'((valid_at.size() > 0) ? valid_at[0] : -1), 32'(P + 6 * H));
        check_output("first_buttons", 32'(cap_buttons), 32'h0C41);
        check_output("first_six", 32'(cap_six), 32'd1);
        check_output("first_present", 32'(cap_present), 32'd1);

        wait_valid(waited);
        check_decode("second", 2, 12'hC41);

        for (int i = 0; i < 16; i++) begin
            pt_list.push_back(int'($urandom_range(0, 2)));
            pr_list.push_back(12'($urandom));
        end
        pt_list.push_back(1); pr_list.push_back(12'h0A0);
        pt_list.push_back(0); pr_list.push_back(12'hFFF);
        pt_list.push_back(1); pr_list.push_back(12'h003);
        pt_list.push_back(1); pr_list.push_back(12'hF0F);
        pt_list.push_back(2); pr_list.push_back(12'hFFF);
        pt_list.push_back(2); pr_list.push_back(12'hC41);
        for (int i = 0; i < pt_list.size(); i++) begin
            apply_stimulus(pt_list[i], pr_list[i]);
            wait_valid(waited);
            check_output($sformatf("poll%0d_period", i), 32'(waited), 32'(P));
            check_decode($sformatf("poll%0d", i), pt_list[i], pr_list[i]);
        end

        apply_stimulus(2, 12'h5A3);
        repeat (P - 6 * H + 3 * H + 1) @(posedge clk);
        #1;
        check_output("ph3_p7", 32'(p7), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_p7", 32'(p7), 32'd1);
        check_output("midrst_buttons", 32'(buttons), 32'd0);
        check_output("midrst_valid", 32'(valid), 32'd0);
        check_output("midrst_six", 32'(six_button), 32'd0);
        check_output("midrst_present", 32'(pad_present), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        waited = -1;
        for (int n = 1; n <= 2 * P; n++) begin
            @(posedge clk);
            #1;
            if (p7 == 1'b0) begin
                waited = n;
                break;
            end
        end
        check_output("midrst_first_fall", 32'(waited), 32'(P + H));
        wait_valid(waited);
        check_output("midrst_valid_delay", 32'(waited), 32'(5 * H));
        check_decode("after_rst", 2, 12'h5A3);

        $display("[TB] directed and random polls complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
